// File: rtl/timer_8b_down.sv
// Loadable down-counting timer with one-shot and auto-reload modes.
// Counts to zero, pulses underflow, then reloads (mode 1) or parks in DONE (mode 0).
module timer_8b_down #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             underflow,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] reload;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      reload    <= '0;
      underflow <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (load) begin
        reload <= load_val;
        count  <= load_val;
        state  <= IDLE;
      end else if (stop && state == RUN) begin
        state <= IDLE;
      end else if (start && state != RUN) begin
        // Restarting after a one-shot expiry begins a fresh period.
        if (state == DONE) begin
          count <= reload;
        end
        state <= RUN;
      end else if (state == RUN) begin
        if (count != '0) begin
          count <= count - 1'b1;
        end else begin
          underflow <= 1'b1;
          if (mode) begin
            count <= reload;
          end else begin
            state <= DONE;
          end
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
